// File: rtl/block_extent_scan.sv
// Extent finder for an NxN piece bitmap: scans one row per clock and reports
// the empty-row/column gap on each of the four edges plus an empty flag.
module block_extent_scan #(
    parameter int N = 3,
    localparam int GW = $clog2(N + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [0:N*N-1]  block,
    output logic            busy,
    output logic            done,
    output logic            empty,
    output logic [GW-1:0]   top_gap,
    output logic [GW-1:0]   bottom_gap,
    output logic [GW-1:0]   left_gap,
    output logic [GW-1:0]   right_gap
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state, state_next;
    logic [0:N*N-1]  shadow;
    logic [GW-1:0]   row;
    logic            seen;
    logic [GW-1:0]   top_idx;
    logic [GW-1:0]   last_idx;
    logic [0:N-1]    col_or;
    logic [0:N-1]    row_bits;
    logic [GW-1:0]   lead_zeros;
    logic [GW-1:0]   trail_zeros;

    // busy covers exactly the states in which a new start is ignored
    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (row == GW'(N - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        row_bits = shadow[int'(row)*N +: N];
    end

    always_comb begin
        lead_zeros  = GW'(N);
        trail_zeros = GW'(N);
        for (int c = N - 1; c >= 0; c--)
            if (col_or[c]) lead_zeros = GW'(c);
        for (int c = 0; c < N; c++)
            if (col_or[c]) trail_zeros = GW'(N - 1 - c);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow     <= '0;
            row        <= '0;
            seen       <= 1'b0;
            top_idx    <= '0;
            last_idx   <= '0;
            col_or     <= '0;
            done       <= 1'b0;
            empty      <= 1'b0;
            top_gap    <= '0;
            bottom_gap <= '0;
            left_gap   <= '0;
            right_gap  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shadow <= block;
                    row    <= '0;
                    seen   <= 1'b0;
                    col_or <= '0;
                end
                SCAN: begin
                    if (|row_bits) begin
                        if (!seen) top_idx <= row;
                        seen     <= 1'b1;
                        last_idx <= row;
                    end
                    col_or <= col_or | row_bits;
                    if (row != GW'(N - 1)) row <= row + GW'(1);
                end
                DONE: begin
                    done <= 1'b1;
                    if (seen) begin
                        empty      <= 1'b0;
                        top_gap    <= top_idx;
                        bottom_gap <= GW'(N - 1) - last_idx;
                        left_gap   <= lead_zeros;
                        right_gap  <= trail_zeros;
                    end else begin
                        empty      <= 1'b1;
                        top_gap    <= GW'(N);
                        bottom_gap <= GW'(N);
                        left_gap   <= GW'(N);
                        right_gap  <= GW'(N);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_block_extent_scan.sv
// Bench for block_extent_scan: directed cases plus random bitmaps for N=3 and
// N=4, compared against a row/column occupancy model of the piece.
module tb_block_extent_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start3 = 1'b0, start4 = 1'b0;
    logic [0:8] block3 = '0;
    logic [0:15] block4 = '0;
    logic busy3, done3, empty3, busy4, done4, empty4;
    logic [1:0] top3, bot3, left3, right3;
    logic [2:0] top4, bot4, left4, right4;

    int errors = 0;
    int checks = 0;

    block_extent_scan #(.N(3)) dut3 (
        .clock(clk), .reset(rst), .start(start3), .block(block3),
        .busy(busy3), .done(done3), .empty(empty3),
        .top_gap(top3), .bottom_gap(bot3), .left_gap(left3), .right_gap(right3));

    block_extent_scan #(.N(4)) dut4 (
        .clock(clk), .reset(rst), .start(start4), .block(block4),
        .busy(busy4), .done(done4), .empty(empty4),
        .top_gap(top4), .bottom_gap(bot4), .left_gap(left4), .right_gap(right4));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: find occupied rows/columns directly from the bitmap.
    task automatic model(input int n, input logic [0:63] bits,
                         output int t, output int b, output int l, output int r, output int e);
        int first_r, last_r, first_c, last_c;
        first_r = -1; last_r = -1; first_c = n; last_c = -1;
        for (int rr = 0; rr < n; rr++)
            for (int cc = 0; cc < n; cc++)
                if (bits[rr*n + cc]) begin
                    if (first_r < 0) first_r = rr;
                    last_r = rr;
                    if (cc < first_c) first_c = cc;
                    if (cc > last_c) last_c = cc;
                end
        if (first_r < 0) begin
            e = 1; t = n; b = n; l = n; r = n;
        end else begin
            e = 0; t = first_r; b = n - 1 - last_r; l = first_c; r = n - 1 - last_c;
        end
    endtask

    function automatic int o_busy(int n); return n == 3 ? int'(busy3) : int'(busy4); endfunction
    function automatic int o_done(int n); return n == 3 ? int'(done3) : int'(done4); endfunction

    task automatic drive(input int n, input logic s, input logic [0:63] bits);
        if (n == 3) begin start3 = s; block3 = bits[0:8]; end
        else        begin start4 = s; block4 = bits[0:15]; end
    endtask

    task automatic check_results(input string tag, input int n, input logic [0:63] bits);
        int t, b, l, r, e;
        model(n, bits, t, b, l, r, e);
        if (n == 3) begin
            chk({tag, ".top"}, int'(top3), t);   chk({tag, ".bottom"}, int'(bot3), b);
            chk({tag, ".left"}, int'(left3), l); chk({tag, ".right"}, int'(right3), r);
            chk({tag, ".empty"}, int'(empty3), e);
        end else begin
            chk({tag, ".top"}, int'(top4), t);   chk({tag, ".bottom"}, int'(bot4), b);
            chk({tag, ".left"}, int'(left4), l); chk({tag, ".right"}, int'(right4), r);
            chk({tag, ".empty"}, int'(empty4), e);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic scan(input string tag, input int n, input logic [0:63] bits);
        int cnt, bcnt;
        drive(n, 1'b1, bits);
        @(negedge clk);
        drive(n, 1'b0, bits);
        cnt = 1; bcnt = o_busy(n);
        while (!o_done(n) && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (o_busy(n) != 0) bcnt++;
        end
        chk({tag, ".latency"}, cnt, n + 2);
        chk({tag, ".busy_cycles"}, bcnt, n + 1);
        check_results(tag, n, bits);
    endtask

    initial begin
        logic [0:63] bits;
        int ndone, t3, b3, l3, r3, e3;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", int'(busy3), 0);
        chk("rst.done", int'(done3), 0);
        chk("rst.gaps", int'({top3, bot3, left3, right3, empty3}), 0);
        rst = 1'b0;
        @(negedge clk);

        bits = '0; bits[0:8] = 9'b010_111_000;
        scan("t1", 3, bits);
        @(negedge clk);
        chk("t1.done_pulse", int'(done3), 0);

        bits = '0; bits[0:8] = 9'b000_000_001;
        scan("t2", 3, bits);

        bits = '0;
        scan("t3_empty", 3, bits);

        bits = '0; bits[0:15] = 16'b0100_0100_0100_0100;
        scan("t4", 4, bits);

        // back-to-back: start asserted in the done cycle is accepted
        bits = '0; bits[0:8] = 9'b100_000_000;
        scan("b2b_a", 3, bits);
        bits = '0; bits[0:8] = 9'b000_000_100;
        scan("b2b_b", 3, bits);
        @(negedge clk);

        // start while busy ignored, block changes after accept ignored
        start3 = 1'b1; block3 = 9'b111_000_000;
        @(negedge clk);
        start3 = 1'b1; block3 = 9'b000_000_000;
        @(negedge clk);
        start3 = 1'b0; block3 = 9'b101_010_011;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done3) begin
                ndone++;
                if (ndone == 1) begin
                    t3 = int'(top3); b3 = int'(bot3); l3 = int'(left3); r3 = int'(right3); e3 = int'(empty3);
                end
            end
            @(negedge clk);
        end
        chk("t5.ndone", ndone, 1);
        chk("t5.top", t3, 0); chk("t5.bottom", b3, 2);
        chk("t5.left", l3, 0); chk("t5.right", r3, 0); chk("t5.empty", e3, 0);

        // reset mid-scan
        start3 = 1'b1; block3 = 9'b001_001_001;
        @(negedge clk);
        start3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6.busy", int'(busy3), 0);
        chk("t6.done", int'(done3), 0);
        chk("t6.outs", int'({top3, bot3, left3, right3, empty3}), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done3) ndone++;
        end
        chk("t6.no_done", ndone, 0);
        bits = '0; bits[0:8] = 9'b000_010_000;
        scan("t6b", 3, bits);

        // random bitmaps, sometimes sparse to reach empty and edge cases
        for (int i = 0; i < 40; i++) begin
            int n;
            n = (i % 2 == 0) ? 3 : 4;
            bits = '0;
            for (int k = 0; k < n*n; k++)
                bits[k] = ($urandom_range(0, 99) < ((i % 3 == 0) ? 8 : 40)) ? 1'b1 : 1'b0;
            @(negedge clk);
            scan($sformatf("rnd%0d_n%0d", i, n), n, bits);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
